// File: rtl/fc_layer_seq.sv
// Stream-to-vector sequencer for a combinational FC layer: gathers IN elements,
// holds them on vec_x, waits LAT cycles, then offers the layer result downstream.
module fc_layer_seq #(
  parameter int WIDTH = 8,
  parameter int IN    = 84,
  parameter int OUT_W = 22,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  output logic [IN*WIDTH-1:0]   vec_x,
  input  logic [OUT_W-1:0]      layer_z,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic                  busy,
  output logic                  err_len,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int WC_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(LAT - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WC_W-1:0]  wcnt;
  logic             s_fire, m_fire, beat_end, wait_done;

  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign beat_end  = (idx == IDX_LAST);
  assign wait_done = (wcnt == WC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (s_fire && beat_end) state_nxt = COMPUTE;
      COMPUTE: if (wait_done)          state_nxt = OUTPUT;
      OUTPUT:  if (m_fire)             state_nxt = LOAD;
      default:                         state_nxt = LOAD;
    endcase
  end

  // s_ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    s_ready = (state == LOAD) && !rst;
    m_valid = (state == OUTPUT);
    busy    = (state != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      wcnt      <= '0;
      vec_x     <= '0;
      m_data    <= '0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      // Length error: full count without s_last, or s_last before full count.
      err_len <= s_fire && (beat_end ^ s_last);
      if (s_fire) begin
        vec_x[idx*WIDTH +: WIDTH] <= s_data;
        idx <= (beat_end || s_last) ? '0 : idx + 1'b1;
      end
      if (state == COMPUTE) begin
        wcnt <= wait_done ? '0 : wcnt + 1'b1;
        if (wait_done) m_data <= layer_z;
      end else begin
        wcnt <= '0;
      end
      if (m_fire) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: LAT=1 and LAT=3 instances, each driving a
// summing layer stub, checked against hand-computed frame sums.
module tb_fc_layer_seq;
  localparam int WIDTH = 8;
  localparam int IN    = 84;
  localparam int OUT_W = 22;
  localparam int CNT_W = 16;
  localparam int LATS [2] = '{1, 3};

  typedef struct {
    int d; int mode; int val; int n; int last_at; int gap;
    int exp_data; int exp_err; int exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] s_data;
  logic s_last, m_ready;
  logic sv [2];
  logic sr [2];
  logic [IN*WIDTH-1:0] vx [2];
  logic [OUT_W-1:0] lz [2];
  logic mv [2];
  logic [OUT_W-1:0] md [2];
  logic bz [2];
  logic er [2];
  logic [CNT_W-1:0] fc [2];

  int checks = 0;
  int errors = 0;
  int exp_fc [2] = '{0, 0};
  vec_t tbl [9];

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] sum_vec(input logic [IN*WIDTH-1:0] v);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int i = 0; i < IN; i++) s += OUT_W'(v[i*WIDTH +: WIDTH]);
    return s;
  endfunction

  assign lz[0] = sum_vec(vx[0]);
  assign lz[1] = sum_vec(vx[1]);

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(s_data),
    .s_last(s_last), .vec_x(vx[0]), .layer_z(lz[0]), .m_valid(mv[0]),
    .m_ready(m_ready), .m_data(md[0]), .busy(bz[0]), .err_len(er[0]),
    .frame_cnt(fc[0]));

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .LAT(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(s_data),
    .s_last(s_last), .vec_x(vx[1]), .layer_z(lz[1]), .m_valid(mv[1]),
    .m_ready(m_ready), .m_data(md[1]), .busy(bz[1]), .err_len(er[1]),
    .frame_cnt(fc[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int d, input int mode, input int val, input int n,
                            input int last_at, input int gap, output int errs);
    errs = 0;
    for (int b = 0; b < n; b++) begin
      if (gap != 0 && b > 0) begin
        cyc();
        if (er[d]) errs++;
      end
      sv[d]  = 1'b1;
      s_data = (mode == 0) ? WIDTH'(b) : WIDTH'(val);
      s_last = (b == last_at);
      cyc();
      if (er[d]) errs++;
      sv[d]  = 1'b0;
      s_last = 1'b0;
    end
  endtask

  task automatic run_row(input vec_t r, input string nm);
    int errs;
    int lat;
    logic quiet;
    send_beats(r.d, r.mode, r.val, r.n, r.last_at, r.gap, errs);
    if (r.exp_out != 0) begin
      lat = 0;
      while (!mv[r.d] && lat < 20) begin
        cyc();
        lat++;
        if (er[r.d]) errs++;
      end
      chk({nm, "_latency"}, lat, LATS[r.d]);
      chk({nm, "_m_data"}, int'(md[r.d]), r.exp_data);
      cyc();
      if (er[r.d]) errs++;
      exp_fc[r.d]++;
      chk({nm, "_frame_cnt"}, int'(fc[r.d]), exp_fc[r.d]);
      chk({nm, "_after_hs"}, {30'd0, mv[r.d], sr[r.d]}, 1);
    end else begin
      quiet = 1'b1;
      repeat (3) begin
        cyc();
        if (er[r.d]) errs++;
        if (mv[r.d] || bz[r.d] || !sr[r.d]) quiet = 1'b0;
      end
      chk({nm, "_no_result"}, int'(quiet), 1);
    end
    chk({nm, "_err_pulses"}, errs, r.exp_err);
  endtask

  initial begin
    int errs;
    logic ok;
    logic [IN*WIDTH-1:0] ramp_vec;
    vec_t r;

    for (int i = 0; i < IN; i++) ramp_vec[i*WIDTH +: WIDTH] = WIDTH'(i);

    tbl[0] = '{0, 0, 0, 84, 83, 0, 3486,  0, 1};
    tbl[1] = '{0, 1, 2, 41, 40, 0, 0,     1, 0};
    tbl[2] = '{0, 1, 2, 84, 83, 0, 168,   0, 1};
    tbl[3] = '{0, 1, 1, 84, -1, 0, 84,    1, 1};
    tbl[4] = '{0, 1, 255, 84, 83, 0, 21420, 0, 1};
    tbl[5] = '{0, 1, 0, 84, 83, 0, 0,     0, 1};
    tbl[6] = '{0, 1, 5, 1, 0, 0, 0,       1, 0};
    tbl[7] = '{1, 1, 3, 84, 83, 1, 252,   0, 1};
    tbl[8] = '{1, 0, 0, 84, 83, 0, 3486,  0, 1};

    rst = 1'b1; sv[0] = 1'b0; sv[1] = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_s_ready", int'(sr[0]), 0);
    chk("rst_outputs", {27'd0, mv[0], bz[0], er[0], (md[0] != '0), (fc[0] != '0)}, 0);
    chk("rst_vec_x_zero", int'(vx[0] == '0), 1);
    rst = 1'b0;
    cyc();
    chk("release_s_ready", {30'd0, sr[0], sr[1]}, 3);

    for (int k = 0; k < 9; k++) run_row(tbl[k], $sformatf("row%0d", k));

    // Backpressure: result and vector must hold while m_ready is low.
    m_ready = 1'b0;
    send_beats(0, 0, 0, 84, 83, 0, errs);
    for (int w = 0; w < 20 && !mv[0]; w++) cyc();
    ok = 1'b1;
    sv[0] = 1'b1; s_data = 8'hAA;
    repeat (10) begin
      if (!mv[0] || md[0] != 22'd3486 || sr[0] || !bz[0] || vx[0] != ramp_vec) ok = 1'b0;
      cyc();
    end
    chk("bp_hold", int'(ok), 1);
    chk("bp_err", errs + int'(er[0]), 0);
    sv[0] = 1'b0;
    m_ready = 1'b1;
    cyc();
    exp_fc[0]++;
    chk("bp_frame_cnt", int'(fc[0]), exp_fc[0]);
    chk("bp_after_hs", {30'd0, mv[0], sr[0]}, 1);

    // Reset while in COMPUTE drops the pending result.
    send_beats(0, 1, 1, 84, 83, 0, errs);
    chk("rc_in_compute", int'(bz[0]), 1);
    rst = 1'b1;
    #1;
    chk("rc_during_rst", {28'd0, mv[0], bz[0], sr[0], (fc[0] != '0)}, 0);
    cyc();
    rst = 1'b0;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    cyc();
    chk("rc_after_release", {30'd0, mv[0], sr[0]}, 1);
    chk("rc_m_data_cleared", int'(md[0]), 0);
    r = '{0, 1, 1, 84, 83, 0, 84, 0, 1};
    run_row(r, "rc_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequencer that feeds one fully-combinational FC neuron layer (IN inputs; constant-coefficient multipliers, adder tree, ReLU) from a narrow element stream.
- Collects IN WIDTH-bit elements into a vector register and holds it stable on the layer inputs.
- Waits a fixed settle/pipeline time, then captures the layer result and presents it on a valid/ready output port.
- Sits between the previous layer's stream output and the next layer's stream input.

Parameters:
- WIDTH, 8, element width (bits) of each layer input.
- IN, 84, number of elements per frame (layer fan-in).
- OUT_W, 22, layer result width (WIDTH*2 + adder-tree growth).
- LAT, 1, cycles to wait after the vector is complete before sampling layer_z; must be >= 1.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  block accepts an element this cycle.
- s_data  in  WIDTH  input element.
- s_last  in  1  marks the final element of a frame.
- vec_x  out  IN*WIDTH  element i at bits [i*WIDTH +: WIDTH]; drives the layer x[i].
- layer_z  in  OUT_W  layer result.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  OUT_W  registered result.
- busy  out  1  high in COMPUTE or OUTPUT.
- err_len  out  1  one-cycle pulse on a frame-length mismatch.
- frame_cnt  out  CNT_W  results delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD, idx=0, vec_x=0, m_data=0, frame_cnt=0, wait counter=0.
  - m_valid=0, err_len=0, busy=0.
  - s_ready forced 0 while rst is high; it is 1 on the first clock after release.
- Handshake: a transfer occurs on a cycle where valid and ready are both high. s_ready does not depend combinationally on s_valid.
- LOAD:
  - s_ready=1.
  - On each accepted beat: vec_x[idx] <= s_data, idx increments.
  - Accepted beat with idx==IN-1: go to COMPUTE, idx <= 0.
    - If s_last=0 on that beat: err_len pulses; the frame is still processed.
  - Accepted beat with idx<IN-1 and s_last=1 (early end):
    - err_len pulses, idx <= 0, stay in LOAD.
    - The partial frame is discarded; vec_x contents are don't-care until overwritten.
- COMPUTE:
  - s_ready=0; vec_x frozen; the wait counter counts LAT cycles.
  - On the LAT-th cycle: m_data <= layer_z, go to OUTPUT.
- OUTPUT:
  - m_valid=1; m_data and vec_x held stable until m_ready.
  - On handshake: m_valid <= 0, frame_cnt increments (wraps), go to LOAD. s_ready is 1 on the next cycle.
- Latency: the last element is accepted at edge t, and m_valid rises after edge t+LAT.
  - With LAT=1: m_valid is visible 2 cycles after the last-beat cycle.
- Throughput: no overlap between loading and output. Minimum frame period is IN + LAT + 1 cycles when m_ready is held high.
- Arithmetic: no arithmetic on data. layer_z is captured bit-exact, is non-negative after ReLU, and is not sign- or zero-extended.
- s_valid gaps: allowed anywhere; idx holds while no transfer occurs.
- s_valid outside LOAD: ignored; no data is lost because s_ready=0.
- Reset mid-operation (any state): immediate return to the reset values. Any pending result is dropped and frame_cnt is cleared.
- err_len: single-cycle pulse, never sticky. Two errors on consecutive beats give two pulses.

Test Plan:
Bench stub models the layer as layer_z = sum of vec_x elements, unsigned, combinational.
- Continuous frame, x[i]=i, s_last on beat 83, m_ready=1, LAT=1 -> m_valid asserted 2 cycles after the last beat, m_data=3486 (0x000D9E), frame_cnt=1, err_len never asserted.
- Same frame with m_ready low for 10 cycles -> m_valid and m_data=3486 stable throughout, s_ready=0, busy=1. After the handshake: s_ready=1 next cycle, frame_cnt=1.
- s_last on beat 40 -> err_len pulses once, no m_valid. The following full frame of all 2s -> m_data=168.
- 84 beats of value 1 with s_last never asserted -> err_len pulse on beat 83, m_data=84 still delivered.
- rst asserted during COMPUTE -> m_valid=0, frame_cnt=0, s_ready=1 one cycle after release. The next frame of all 1s -> m_data=84, frame_cnt=1.
- LAT=3 build, s_valid toggling every other cycle, x[i]=3 -> all 84 elements captured, m_valid 4 cycles after the last beat, m_data=252.
